uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and serializer that shares one UART transmit line among `N_REQ` byte sources in the ASCII-print design. It holds the bit-period counter that divides the 100 MHz system clock down to the baud rate, so no separate divided clock is needed. It accepts one byte per grant through a valid/ready handshake and emits a complete 8N1 frame (start, 8 data LSB-first, stop) on `tx_serial`.

## Interface
- `CLKS_PER_BIT`, 10417: system clocks per UART bit (9600 baud at 100 MHz); legal range ≥ 2.
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `Clock_100MHz` in 1: system clock; all logic on its rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: bit i high = requester i has a byte pending.
- `req_data` in 8*N_REQ: byte for requester i is at bits [8i+7:8i].
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse to the granted requester.
- `tx_serial` out 1: UART line; idles high.
- `busy` out 1: high while a frame is in progress.
- `grant_id` out 3: index of the requester whose frame is current or was last sent.

## Operation
- Reset values: `tx_serial`=1, `busy`=0, `req_ready`=0, `grant_id`=0. The round-robin pointer resets to `N_REQ-1`, so requester 0 has first priority.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if any `req_valid` bit is high, select the first set bit searching from pointer+1 upward with wrap-around. Then:
  - Assert that requester's `req_ready` bit for one cycle.
  - Latch its byte into the shift register and set `grant_id`.
  - Update the pointer to the winner and go to START.
  - If no `req_valid` bit is high, stay in IDLE with `tx_serial`=1.
- START: drive `tx_serial`=0 for one bit period, then go to DATA.
- DATA: drive the shift register LSB for one bit period, shift right, and repeat 8 times using a 3-bit bit index. After bit 7, go to STOP.
- STOP: drive `tx_serial`=1 for one bit period, then go to IDLE.
- Bit-period counter:
  - Width is ceil(log2(CLKS_PER_BIT)).
  - It clears on the grant cycle, counts 0..CLKS_PER_BIT-1, and wraps to 0 at each bit boundary.
  - It is held at 0 in IDLE.
- Requesters hold `req_valid` and `req_data` stable until they see their `req_ready` pulse. A requester that drops `req_valid` before the grant is simply not selected.
- `req_valid` and `req_data` changes after the grant have no effect on the current frame.
- `busy` is high in START, DATA and STOP, and low in IDLE.
- If the same requester is the only one asserting valid, it is granted on back-to-back frames.

## Timing
- Grant cycle T: `req_ready` is high during T; the state is START from T+1.
- `tx_serial` falls at T+1 (registered output).
- Start bit occupies T+1 .. T+CLKS_PER_BIT.
- Data bit k occupies T+1+(k+1)·CLKS_PER_BIT for CLKS_PER_BIT cycles.
- Stop bit ends at T+10·CLKS_PER_BIT. IDLE is entered at T+10·CLKS_PER_BIT+1, and the next grant can occur in that same cycle.
  - Frame-to-frame spacing is therefore 10·CLKS_PER_BIT+1 cycles when requests are continuous.
- Simultaneous requests resolve in the single IDLE cycle; there is never more than one `req_ready` bit high.
- Reset asserted mid-frame:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The partial frame is abandoned and `tx_serial` returns high at once.
  - After release, the first grant occurs on the first clock edge with a `req_valid` bit high.
- Requests arriving while `busy`=1 wait; no grant is issued until IDLE.

## Test plan
- Reset and idle: assert `Reset` mid-simulation with no requests, then release → `tx_serial`=1, `busy`=0, `req_ready`=0 and `grant_id`=0 for 100 cycles.
- Single frame (CLKS_PER_BIT=4): `req_valid[2]`=1 with data 0x41 → `req_ready`=4'b0100 for one cycle and `grant_id`=2. `tx_serial` then reads 0,1,0,0,0,0,0,1,0,1, each held 4 cycles, and `busy` is high for exactly 40 cycles.
- Round-robin fairness: all four requesters hold valid continuously with data 0x30+i → grants go 0,1,2,3,0,1 with frame starts 41 cycles apart, and each frame carries its requester's byte.
- Skip of idle requesters: only requesters 1 and 3 are valid, pointer at 3 → grant order 1,3,1,3, with no `req_ready` pulse ever on bits 0 or 2.
- Request during busy: raise `req_valid[0]` at bit 4 of requester 3's frame → no `req_ready` until the IDLE cycle right after the stop bit, then a grant to 0 in that cycle.
- Reset mid-frame: assert `Reset` during data bit 3 → `tx_serial`=1 and `busy`=0 with no clock edge needed. After release, a pending `req_valid[1]` is granted first and a full, correct frame follows.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between the byte sources and the shared UART transmitter.
// The arbiter connects through the slave modport; requesters and the bench use master.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0]   req_valid;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_ready;
   logic               tx_serial;
   logic               busy;
   logic [2:0]         grant_id;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  tx_serial,
      input  busy,
      input  grant_id
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output tx_serial,
      output busy,
      output grant_id
   );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that takes one byte per grant and serializes it as an 8N1 frame
// on a single UART line, dividing the system clock down to the bit rate internally.
module uart_tx_arbiter #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int N_REQ        = 4
) (
   input logic              Clock_100MHz,
   input logic              Reset,
   uart_tx_arbiter_if.slave bus
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
   logic [2:0]       bit_idx, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic [2:0]       rr_ptr, rr_ptr_next;
   logic [2:0]       grant_id, grant_id_next;
   logic             tx_reg, tx_next;

   logic             win_found;
   logic [2:0]       win_idx;
   logic [N_REQ-1:0] win_onehot;
   logic [7:0]       win_byte;
   logic             bit_done;

   assign bit_done = (bit_cnt == CNT_LAST);

   // Two passes give wrap-around priority: first the indices above the pointer, then the rest.
   always_comb begin
      win_found  = 1'b0;
      win_idx    = '0;
      win_onehot = '0;
      win_byte   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && (i > int'(rr_ptr)) && bus.req_valid[i]) begin
            win_found     = 1'b1;
            win_idx       = 3'(i);
            win_onehot[i] = 1'b1;
            win_byte      = bus.req_data[8*i +: 8];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && (i <= int'(rr_ptr)) && bus.req_valid[i]) begin
            win_found     = 1'b1;
            win_idx       = 3'(i);
            win_onehot[i] = 1'b1;
            win_byte      = bus.req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_next    = state;
      bit_cnt_next  = bit_cnt;
      bit_idx_next  = bit_idx;
      shift_next    = shift_reg;
      rr_ptr_next   = rr_ptr;
      grant_id_next = grant_id;
      tx_next       = tx_reg;
      case (state)
         IDLE: begin
            bit_cnt_next = '0;
            tx_next      = 1'b1;
            if (win_found) begin
               state_next    = START;
               shift_next    = win_byte;
               grant_id_next = win_idx;
               rr_ptr_next   = win_idx;
               bit_idx_next  = '0;
               tx_next       = 1'b0;
            end
         end
         START: begin
            if (bit_done) begin
               bit_cnt_next = '0;
               state_next   = DATA;
               tx_next      = shift_reg[0];
            end else begin
               bit_cnt_next = bit_cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               bit_cnt_next = '0;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + 3'd1;
                  shift_next   = {1'b0, shift_reg[7:1]};
                  tx_next      = shift_reg[1];
               end
            end else begin
               bit_cnt_next = bit_cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               bit_cnt_next = '0;
               state_next   = IDLE;
               tx_next      = 1'b1;
            end else begin
               bit_cnt_next = bit_cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clock_100MHz or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         rr_ptr    <= 3'(N_REQ - 1);
         grant_id  <= '0;
         tx_reg    <= 1'b1;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
         rr_ptr    <= rr_ptr_next;
         grant_id  <= grant_id_next;
         tx_reg    <= tx_next;
      end
   end

   // The accept pulse is combinational, so it is gated by reset to stay low while reset is held.
   assign bus.req_ready = (state == IDLE && !Reset) ? win_onehot : '0;
   assign bus.busy      = (state != IDLE);
   assign bus.tx_serial = tx_reg;
   assign bus.grant_id  = grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short bit period: a frame table applied in a
// loop, plus hand-written sequences for reset, request-while-busy and reset mid-frame.
module tb_uart_tx_arbiter;

   localparam int CPB      = 4;
   localparam int NREQ     = 4;
   localparam int NVEC     = 11;
   localparam int CLK_PER  = 10;

   typedef struct {
      logic        resetFirst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic [2:0]  expGrant;
      logic [7:0]  expByte;
      logic        checkSpacing;
   } frameVec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vecCount = 0;
   int   missCount = 0;

   frameVec_t   vecs [NVEC];
   int          waited;
   longint      lastGrant;
   longint      nowTime;
   logic [3:0]  expReady;
   int          badCycles;

   uart_tx_arbiter_if #(.N_REQ(NREQ)) bus ();

   uart_tx_arbiter #(
      .CLKS_PER_BIT(CPB),
      .N_REQ(NREQ)
   ) dut (
      .Clock_100MHz(clk),
      .Reset(reset),
      .bus(bus)
   );

   always #(CLK_PER/2) clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data);
      bus.req_valid = valid;
      bus.req_data  = data;
   endtask

   task automatic doReset();
      reset = 1'b1;
      applyStimulus(4'b0000, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Returns as soon as a req_ready pulse is visible; a grant cycle is a negedge (+1) sample point.
   task automatic waitGrant(output int cycles);
      #1;
      cycles = 0;
      while (!(|bus.req_ready) && cycles < 200) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      checkOutput("grant_seen", 32'(|bus.req_ready), 32'd1);
   endtask

   // Called right after the grant edge; samples cycles 1..41 of the frame on falling edges.
   task automatic checkFrame(input string tag, input logic [7:0] b, input logic [2:0] expGid,
                             input int raiseAt, input logic [3:0] raiseValid, input logic [31:0] raiseData);
      logic       samp [1:41];
      logic [3:0] seen;
      logic       expBit;
      int         busyCycles;
      int         readyPulses;
      busyCycles  = 0;
      readyPulses = 0;
      for (int c = 1; c <= 41; c++) begin
         @(negedge clk);
         samp[c] = bus.tx_serial;
         if (bus.busy) busyCycles++;
         if ((|bus.req_ready) && c <= 40) readyPulses++;
         if (c == 1) checkOutput({tag, "_grant_id"}, 32'(bus.grant_id), 32'(expGid));
         if (c == raiseAt) applyStimulus(raiseValid, raiseData);
      end
      for (int j = 0; j < 10; j++) begin
         expBit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
         seen   = {samp[4*j+1], samp[4*j+2], samp[4*j+3], samp[4*j+4]};
         checkOutput($sformatf("%s_bit%0d", tag, j), 32'(seen), 32'({4{expBit}}));
      end
      checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'd40);
      checkOutput({tag, "_ready_in_frame"}, 32'(readyPulses), 32'd0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 4'b0100, 32'h3341_3130, 3'd2, 8'h41, 1'b0};
      vecs[1]  = '{1'b1, 4'b1111, 32'h3332_3130, 3'd0, 8'h30, 1'b0};
      vecs[2]  = '{1'b0, 4'b1111, 32'h3332_3130, 3'd1, 8'h31, 1'b1};
      vecs[3]  = '{1'b0, 4'b1111, 32'h3332_3130, 3'd2, 8'h32, 1'b1};
      vecs[4]  = '{1'b0, 4'b1111, 32'h3332_3130, 3'd3, 8'h33, 1'b1};
      vecs[5]  = '{1'b0, 4'b1111, 32'h3332_3130, 3'd0, 8'h30, 1'b1};
      vecs[6]  = '{1'b0, 4'b1111, 32'h3332_3130, 3'd1, 8'h31, 1'b1};
      vecs[7]  = '{1'b1, 4'b1010, 32'h3332_3130, 3'd1, 8'h31, 1'b0};
      vecs[8]  = '{1'b0, 4'b1010, 32'h3332_3130, 3'd3, 8'h33, 1'b1};
      vecs[9]  = '{1'b0, 4'b1010, 32'h3332_3130, 3'd1, 8'h31, 1'b1};
      vecs[10] = '{1'b0, 4'b1010, 32'h3332_3130, 3'd3, 8'h33, 1'b1};
      lastGrant = 0;

      // Reset with no requests: outputs go idle at once and stay idle afterwards.
      doReset();
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("rst_tx", 32'(bus.tx_serial), 32'd1);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      badCycles = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (bus.tx_serial !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000 || bus.grant_id !== 3'd0)
            badCycles++;
      end
      checkOutput("idle_100_cycles", 32'(badCycles), 32'd0);

      // Frame table: single frame, continuous round-robin, skipping idle requesters.
      for (int k = 0; k < NVEC; k++) begin
         if (vecs[k].resetFirst) doReset();
         applyStimulus(vecs[k].valid, vecs[k].data);
         waitGrant(waited);
         nowTime  = longint'($time);
         expReady = 4'b0001 << vecs[k].expGrant;
         checkOutput($sformatf("v%0d_ready", k), 32'(bus.req_ready), 32'(expReady));
         if (vecs[k].checkSpacing)
            checkOutput($sformatf("v%0d_spacing", k), 32'((nowTime - lastGrant) / CLK_PER), 32'd41);
         lastGrant = nowTime;
         @(posedge clk);
         #1;
         if (k < NVEC - 1) begin
            if (!vecs[k+1].resetFirst) applyStimulus(vecs[k+1].valid, vecs[k+1].data);
            else applyStimulus(4'b0000, vecs[k].data);
         end else begin
            applyStimulus(4'b0000, vecs[k].data);
         end
         checkFrame($sformatf("v%0d", k), vecs[k].expByte, vecs[k].expGrant, 0, 4'b0000, 32'h0);
      end

      // Request while busy: requester 0 raises valid during data bit 4 of requester 3's frame.
      doReset();
      applyStimulus(4'b1000, 32'h3300_0000);
      waitGrant(waited);
      checkOutput("busy_req_first_ready", 32'(bus.req_ready), 32'h8);
      @(posedge clk);
      #1;
      applyStimulus(4'b0000, 32'h3300_0000);
      checkFrame("busy_f3", 8'h33, 3'd3, 22, 4'b0001, 32'h3300_0055);
      checkOutput("busy_req_grant_after_stop", 32'(bus.req_ready), 32'h1);
      checkOutput("busy_req_idle_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(4'b0000, 32'h3300_0055);
      checkFrame("busy_f0", 8'h55, 3'd0, 0, 4'b0000, 32'h0);

      // Reset during data bit 3, with requester 1 pending behind the aborted frame.
      doReset();
      applyStimulus(4'b0100, 32'h00A5_0000);
      waitGrant(waited);
      checkOutput("midrst_first_ready", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1;
      applyStimulus(4'b0010, 32'h0000_3C00);
      for (int c = 1; c <= 18; c++) @(negedge clk);
      checkOutput("midrst_busy_before", 32'(bus.busy), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midrst_tx", 32'(bus.tx_serial), 32'd1);
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrst_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("midrst_grant_id", 32'(bus.grant_id), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      waitGrant(waited);
      checkOutput("midrst_first_edge", 32'(waited), 32'd0);
      checkOutput("midrst_ready_after", 32'(bus.req_ready), 32'h2);
      @(posedge clk);
      #1;
      applyStimulus(4'b0000, 32'h0000_3C00);
      checkFrame("midrst_f1", 8'h3C, 3'd1, 0, 4'b0000, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
